adc_sample_framer: RTL

Downstream consumer of the ADC driver's `toMem` sample stream. It groups consecutive per-channel samples from one conversion cycle into a single multi-channel frame, tags each frame with a sequence number, and buffers frames in a small FIFO. Frames leave through a valid/ready interface to the localization DSP. Overflow and short-frame conditions are counted rather than stalling the ADC, which cannot be back-pressured.

---
 rtl/adc_sample_framer_if.sv | 34 +++
 rtl/adc_sample_framer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/adc_sample_framer_if.sv
// Sample-in / frame-out bundle for adc_sample_framer; slave is the framer,
// master is whoever feeds samples and consumes frames.
interface adc_sample_framer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0]        sample_in;
   logic                     sample_valid;
   logic                     frame_start;
   logic [NUM_CH*DATA_W-1:0] frame_data;
   logic [15:0]              frame_seq;
   logic [31:0]              frame_ts;
   logic                     frame_valid;
   logic                     frame_ready;
   logic [LVL_W-1:0]         fifo_level;
   logic                     overflow;
   logic [15:0]              drop_count;
   logic [15:0]              short_count;

   modport master (
      output sample_in, sample_valid, frame_start, frame_ready,
      input  frame_data, frame_seq, frame_ts, frame_valid, fifo_level,
             overflow, drop_count, short_count
   );

   modport slave (
      input  sample_in, sample_valid, frame_start, frame_ready,
      output frame_data, frame_seq, frame_ts, frame_valid, fifo_level,
             overflow, drop_count, short_count
   );
endinterface

// File: rtl/adc_sample_framer.sv
// Groups per-channel ADC samples into sequence-tagged frames buffered in a FWFT FIFO.
// Optional capture timestamps are enabled with ADC_FRAMER_TIMESTAMP_EN.
module adc_sample_framer #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input logic                clk,
   input logic                rst,
   adc_sample_framer_if.slave bus
);
   localparam int CH_W    = $clog2(NUM_CH);
   localparam int AW      = $clog2(DEPTH);
   localparam int FRAME_W = NUM_CH * DATA_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ch_idx, ch_nxt, wr_idx;
   logic              first_wr, slot_we, commit, short_evt;
   logic [DATA_W-1:0] slot [NUM_CH-1];
   logic [FRAME_W-1:0] commit_data;

   logic [AW:0]        wr_ptr, rd_ptr;
   logic               empty, full, pop, push, drop;
   logic [FRAME_W-1:0] data_mem [DEPTH];
   logic [15:0]        seq_mem  [DEPTH];
   logic [15:0]        seq_ctr, drop_cnt, short_cnt;
   logic               ovf;

   // A strobe coinciding with frame_start always lands in slot 0.
   assign first_wr = bus.sample_valid && (bus.frame_start || state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ch_idx <= '0;
      end else begin
         state  <= state_nxt;
         ch_idx <= ch_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch_idx;
      wr_idx    = ch_idx;
      slot_we   = 1'b0;
      commit    = 1'b0;
      short_evt = bus.frame_start && state == FILL;
      if (first_wr) begin
         wr_idx    = '0;
         slot_we   = 1'b1;
         state_nxt = FILL;
         ch_nxt    = CH_W'(1);
      end else if (bus.sample_valid) begin
         slot_we = 1'b1;
         if (ch_idx == CH_W'(NUM_CH - 1)) begin
            commit    = 1'b1;
            state_nxt = IDLE;
            ch_nxt    = '0;
         end else begin
            ch_nxt = ch_idx + CH_W'(1);
         end
      end else if (bus.frame_start) begin
         state_nxt = IDLE;
         ch_nxt    = '0;
      end
   end

   // The last channel is never stored; it goes straight into the FIFO entry.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
         if (slot_we && wr_idx == CH_W'(i)) slot[i] <= bus.sample_in;
      end
   end

   always_comb begin
      commit_data = '0;
      for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
         commit_data[i*DATA_W +: DATA_W] = slot[i];
      end
      commit_data[(NUM_CH-1)*DATA_W +: DATA_W] = bus.sample_in;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && bus.frame_ready;
   assign push  = commit && (!full || pop);
   assign drop  = commit && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr[AW-1:0]] <= commit_data;
         seq_mem[wr_ptr[AW-1:0]]  <= seq_ctr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         seq_ctr   <= '0;
         drop_cnt  <= '0;
         short_cnt <= '0;
         ovf       <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (commit) seq_ctr <= seq_ctr + 16'd1;
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
         end
         if (short_evt && short_cnt != '1) short_cnt <= short_cnt + 16'd1;
      end
   end

   assign bus.frame_valid = !empty;
   assign bus.frame_data  = empty ? '0 : data_mem[rd_ptr[AW-1:0]];
   assign bus.frame_seq   = empty ? '0 : seq_mem[rd_ptr[AW-1:0]];
   assign bus.fifo_level  = wr_ptr - rd_ptr;
   assign bus.overflow    = ovf;
   assign bus.drop_count  = drop_cnt;
   assign bus.short_count = short_cnt;

`ifdef ADC_FRAMER_TIMESTAMP_EN
   logic [31:0] ts_ctr, ts_hold;
   logic [31:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         ts_ctr  <= '0;
         ts_hold <= '0;
      end else begin
         ts_ctr <= ts_ctr + 32'd1;
         if (first_wr) ts_hold <= ts_ctr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) ts_mem[wr_ptr[AW-1:0]] <= ts_hold;
   end

   assign bus.frame_ts = empty ? '0 : ts_mem[rd_ptr[AW-1:0]];
`else
   assign bus.frame_ts = '0;
`endif
endmodule
